// File: rtl/count_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | count_monitor - lock/step checker for a 3-bit up-counter.                  |
// | Optional: COUNT_MON_STALL_EN (stalls are neutral). Rev 1.0                 |
// +----------------------------------------------------------------------------+
module count_monitor #(
  parameter int LOCK_N = 4,
  parameter int ERR_W  = 8,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        count,
  input  logic              clr,
  output logic              locked,
  output logic              err,
  output logic              wrap,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [WRAP_W-1:0] wraps
);

  typedef enum logic [1:0] {
    ACQ    = 2'd0,
    RESYNC = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0]        LOCK_RUN = 4'(LOCK_N);
  localparam logic [ERR_W-1:0]  ERR_ONE  = ERR_W'(1);
  localparam logic [WRAP_W-1:0] WRAP_ONE = WRAP_W'(1);
  localparam logic [ERR_W-1:0]  ERR_MAX  = '1;

  state_t            state, state_nxt;
  logic [2:0]        prev, prev_nxt;
  logic [3:0]        good_run, good_run_nxt;
  logic              err_nxt, wrap_nxt, locked_nxt;
  logic [ERR_W-1:0]  err_cnt_nxt;
  logic [WRAP_W-1:0] wraps_nxt;

  logic good_step;
  logic bad_step;
  logic hold;
  logic wrap_step;

  assign good_step = (count == 3'(prev + 3'd1));
  assign wrap_step = (prev == 3'd7) && (count == 3'd0);

`ifdef COUNT_MON_STALL_EN
  // A repeated sample means the upstream counter was not enabled this cycle.
  assign hold     = (count == prev);
  assign bad_step = !good_step && !hold;
`else
  assign hold     = 1'b0;
  assign bad_step = !good_step;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ACQ;
      prev     <= 3'd0;
      good_run <= 4'd0;
      locked   <= 1'b0;
      err      <= 1'b0;
      wrap     <= 1'b0;
      err_cnt  <= '0;
      wraps    <= '0;
    end else begin
      state    <= state_nxt;
      prev     <= prev_nxt;
      good_run <= good_run_nxt;
      locked   <= locked_nxt;
      err      <= err_nxt;
      wrap     <= wrap_nxt;
      err_cnt  <= err_cnt_nxt;
      wraps    <= wraps_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    prev_nxt     = count;
    good_run_nxt = good_run;
    err_nxt      = 1'b0;
    wrap_nxt     = 1'b0;
    err_cnt_nxt  = err_cnt;
    wraps_nxt    = wraps;

    if (clr) begin
      state_nxt    = ACQ;
      prev_nxt     = 3'd0;
      good_run_nxt = 4'd0;
      err_cnt_nxt  = '0;
      wraps_nxt    = '0;
    end else begin
      case (state)
        ACQ: begin
          good_run_nxt = 4'd0;
          state_nxt    = RESYNC;
        end
        RESYNC: begin
          if (hold) begin
            good_run_nxt = good_run;
          end else if (good_step) begin
            good_run_nxt = good_run + 4'd1;
            if (good_run_nxt == LOCK_RUN) begin
              state_nxt = LOCKED;
            end
          end else begin
            good_run_nxt = 4'd0;
          end
        end
        LOCKED: begin
          if (bad_step) begin
            err_nxt      = 1'b1;
            good_run_nxt = 4'd0;
            state_nxt    = RESYNC;
            if (err_cnt != ERR_MAX) begin
              err_cnt_nxt = err_cnt + ERR_ONE;
            end
          end
        end
        default: begin
          state_nxt    = ACQ;
          good_run_nxt = 4'd0;
        end
      endcase

      // The ACQ sample has no predecessor, so it can never form a wrap step.
      if ((state == RESYNC || state == LOCKED) && wrap_step) begin
        wrap_nxt  = 1'b1;
        wraps_nxt = wraps + WRAP_ONE;
      end
    end

    locked_nxt = (state_nxt == LOCKED);
  end

endmodule
`default_nettype wire

// File: tb/tb_count_monitor.sv
`default_nettype none
// tb_count_monitor - directed and random stimulus against a behavioural model.
`timescale 1ns/1ps
module tb_count_monitor;

  localparam int LOCK_N = 4;
  localparam int ERR_W  = 2;
  localparam int WRAP_W = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              clr = 1'b0;
  logic [2:0]        count = 3'd0;
  logic              locked, err, wrap;
  logic [ERR_W-1:0]  err_cnt;
  logic [WRAP_W-1:0] wraps;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  bit       m_acq = 1'b1;
  bit       m_locked = 1'b0;
  bit       m_err = 1'b0;
  bit       m_wrap = 1'b0;
  int       m_run = 0;
  int       m_prev = 0;
  int       m_errs = 0;
  int       m_wraps = 0;

  int       cur = 0;
  int       err_tally = 0;
  int       wrap_tally = 0;

  count_monitor #(.LOCK_N(LOCK_N), .ERR_W(ERR_W), .WRAP_W(WRAP_W)) dut (
    .clk(clk), .rst(rst), .count(count), .clr(clr),
    .locked(locked), .err(err), .wrap(wrap), .err_cnt(err_cnt), .wraps(wraps)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_acq = 1'b1; m_locked = 1'b0; m_run = 0; m_prev = 0;
    m_errs = 0; m_wraps = 0; m_err = 1'b0; m_wrap = 1'b0;
  endtask

  task automatic model_step(input int c, input bit cl);
    bit good, stall;
    m_err = 1'b0;
    m_wrap = 1'b0;
    if (cl) begin
      model_clear();
      return;
    end
    if (m_acq) begin
      m_acq = 1'b0; m_run = 0; m_prev = c;
      return;
    end
    good  = (c == (m_prev + 1) % 8);
    stall = (c == m_prev);
`ifdef COUNT_MON_STALL_EN
    if (stall) begin
      m_prev = c;
      return;
    end
`endif
    if (good) begin
      if (m_prev == 7) begin
        m_wrap = 1'b1;
        m_wraps++;
      end
      if (!m_locked) begin
        m_run++;
        if (m_run == LOCK_N) m_locked = 1'b1;
      end
    end else begin
      if (m_locked) begin
        m_err = 1'b1;
        m_errs++;
        m_locked = 1'b0;
      end
      m_run = 0;
    end
    m_prev = c;
  endtask

  function automatic int exp_err_cnt();
    int mx = (1 << ERR_W) - 1;
    return (m_errs > mx) ? mx : m_errs;
  endfunction

  // Entered at a negedge; drives one sample, checks after the posedge.
  task automatic step(input int c, input bit cl);
    count = 3'(c);
    clr   = cl;
    @(posedge clk);
    #1;
    model_step(c, cl);
    check("locked",  32'(locked),  32'(m_locked));
    check("err",     32'(err),     32'(m_err));
    check("wrap",    32'(wrap),    32'(m_wrap));
    check("err_cnt", 32'(err_cnt), 32'(exp_err_cnt()));
    check("wraps",   32'(wraps),   32'(m_wraps % (1 << WRAP_W)));
    if (err)  err_tally++;
    if (wrap) wrap_tally++;
    cur = c;
    @(negedge clk);
  endtask

  task automatic good_steps(input int n);
    for (int k = 0; k < n; k++) step((cur + 1) % 8, 1'b0);
  endtask

  initial begin
    int bad_seq[6] = '{3, 5, 6, 7, 0, 1};
    int r;

    @(posedge clk);
    #1;
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_wrap", 32'(wrap), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_wraps", 32'(wraps), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // lock and wrap from a clean 0,1,2,... sequence
    for (int i = 0; i <= 10; i++) begin
      step(i % 8, 1'b0);
      if (i == 3) check("pre_lock", 32'(locked), 32'd0);
      if (i == 4) check("lock_edge5", 32'(locked), 32'd1);
      if (i == 8) begin
        check("first_wrap", 32'(wrap), 32'd1);
        check("first_wraps", 32'(wraps), 32'd1);
      end
    end

    // bad step while locked, relock four good steps later
    for (int i = 0; i < 6; i++) begin
      step(bad_seq[i], 1'b0);
      if (i == 1) begin
        check("bad_err", 32'(err), 32'd1);
        check("bad_err_cnt", 32'(err_cnt), 32'd1);
        check("bad_unlock", 32'(locked), 32'd0);
      end
      if (i == 4) check("relock_pre", 32'(locked), 32'd0);
      if (i == 5) check("relock", 32'(locked), 32'd1);
    end

    // saturation: five more lock/bad cycles
    err_tally = 0;
    for (int i = 0; i < 5; i++) begin
      step((cur + 3) % 8, 1'b0);
      good_steps(LOCK_N);
    end
    check("sat_err_cnt", 32'(err_cnt), 32'd3);
    check("sat_pulses", 32'(err_tally), 32'd5);

    // stall while locked
    step((cur + 1) % 8, 1'b0);
    step(cur, 1'b0);
`ifdef COUNT_MON_STALL_EN
    check("stall_locked", 32'(locked), 32'd1);
`else
    check("stall_err", 32'(err), 32'd1);
`endif
    step((cur + 1) % 8, 1'b0);
    good_steps(LOCK_N);

    // synchronous clear mid-run, relock after 1+LOCK_N edges
    step((cur + 1) % 8, 1'b1);
    check("clr_locked", 32'(locked), 32'd0);
    check("clr_err_cnt", 32'(err_cnt), 32'd0);
    check("clr_wraps", 32'(wraps), 32'd0);
    good_steps(1 + LOCK_N);
    check("clr_relock", 32'(locked), 32'd1);

    // asynchronous reset between edges
    good_steps(3);
    #1 rst = 1'b1;
    #1;
    check("arst_locked", 32'(locked), 32'd0);
    check("arst_err_cnt", 32'(err_cnt), 32'd0);
    check("arst_wraps", 32'(wraps), 32'd0);
    #1 rst = 1'b0;
    model_clear();
    good_steps(1 + LOCK_N);
    check("arst_relock", 32'(locked), 32'd1);

    // wrap rollover across four counter periods
    step((cur + 1) % 8, 1'b1);
    step((cur + 1) % 8, 1'b0);
    wrap_tally = 0;
    good_steps(32);
    check("roll_pulses", 32'(wrap_tally), 32'd4);
    check("roll_wraps", 32'(wraps), 32'd0);

    // random mix of good steps, stalls, jumps and clears
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(99);
      if (r < 78)      step((cur + 1) % 8, 1'b0);
      else if (r < 87) step(cur, 1'b0);
      else if (r < 96) step($urandom_range(7), 1'b0);
      else             step($urandom_range(7), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/count_monitor.md
# count_monitor

Sequence checker that sits directly downstream of the 3-bit free-running up-counter and consumes its `count` bus every clock. It verifies that each sample is the previous sample plus one, modulo 8. It acquires and locks onto the sequence, and flags and counts step errors. It also counts 7→0 wrap events for use by later stages and the bench.

## Interface
- `LOCK_N`, 4: consecutive good steps required to enter LOCKED (1..15).
- `ERR_W`, 8: width of saturating error counter.
- `WRAP_W`, 8: width of wrap counter; rolls over modulo 2^WRAP_W.

Ports:
- `clk`  in  1  rising-edge clock, shared with the counter.
- `rst`  in  1  asynchronous, active-high reset.
- `count`  in  3  counter value, sampled every posedge.
- `clr`  in  1  synchronous clear of FSM and statistics.
- `locked`  out  1  high while FSM is in LOCKED.
- `err`  out  1  one-cycle pulse on a bad step while LOCKED.
- `wrap`  out  1  one-cycle pulse on a 7→0 step.
- `err_cnt`  out  ERR_W  saturating count of `err` pulses.
- `wraps`  out  WRAP_W  count of `wrap` pulses, wrapping.

## Operation
- Internal registers:
  - `prev[2:0]`: last sample.
  - `good_run[3:0]`: count of consecutive good steps.
  - 2-bit state.
- Definitions:
  - Good step: `count == prev + 1` in 3-bit arithmetic, so 7→0 is good.
  - Stall: `count == prev`.
  - Any other value is a bad step.
- FSM states: ACQ, RESYNC, LOCKED. Reset and `clr` state is ACQ.
- ACQ:
  - Capture `prev <= count`, set `good_run <= 0`.
  - Go to RESYNC.
  - No step is evaluated, so no `err` and no `wrap`.
- RESYNC:
  - Good step: increment `good_run`. When the new value equals `LOCK_N`, go to LOCKED.
  - Bad step: set `good_run <= 0`, stay in RESYNC, no `err`.
- LOCKED:
  - Good step: stay in LOCKED.
  - Bad step: pulse `err`, increment `err_cnt` (saturating at all-ones), set `good_run <= 0`, go to RESYNC.
- In RESYNC and LOCKED, `prev <= count` every cycle.
- `wrap` pulses on any step with `prev == 7` and `count == 0` in RESYNC or LOCKED. `wraps` increments on that step.
- `clr` has priority over all step evaluation:
  - Next state ACQ.
  - `err_cnt`, `wraps`, `good_run` and `prev` are set to 0.
  - `err` and `wrap` are 0.
  - The sample taken on that edge is discarded.
- Reset values:
  - `locked`, `err`, `wrap`: 0.
  - `err_cnt`, `wraps`: 0.
  - `prev`, `good_run`: 0.
  - State: ACQ.

## Timing
- All outputs are registered; there is no combinational path from `count` or `clr` to any output.
- Latency: a step sampled at edge k drives `err`/`wrap`/counter updates visible from edge k until edge k+1.
- From reset release with a clean sequence:
  - First edge: ACQ.
  - `locked` rises after edge 1+`LOCK_N` (edge 5 with the default `LOCK_N`).
- `locked` falls on the same edge on which `err` rises.
- `rst` asserted mid-operation clears all state and outputs immediately, without waiting for a clock edge.
- First edge after `rst` deasserts is treated as ACQ.
- `err_cnt` at all-ones stays there; `err` still pulses.

## Configuration
- `COUNT_MON_STALL_EN` defined:
  - A stall is neutral in every state: no `err`, `good_run` unchanged, state unchanged, no `wrap`.
  - Supports a counter that is clock-enabled upstream.
- Not defined: a stall is a bad step.

## Test plan
- **Lock and wrap:** rst 1→0, then counter 0,1,2,…
  - `locked` = 1 after the 5th sample edge.
  - On the 7→0 sample, `wrap` is high for one cycle and `wraps` = 1.
  - `err_cnt` = 0 throughout.
- **Bad step:** while locked, drive 2,3,5,6,7,0,1.
  - At the 5 sample: `err` pulses once, `err_cnt` = 1, `locked` = 0.
  - `locked` returns 4 good steps later, on the 1 sample.
- **Saturation:** `ERR_W` = 2; force 5 lock/bad cycles.
  - `err_cnt` stops at 3.
  - `err` pulses 5 times.
- **Stall:** while locked, drive 4,4,5.
  - With `COUNT_MON_STALL_EN`: no `err`, `locked` stays 1.
  - Without it: `err` at the second 4, and `err_cnt` increments.
- **Clear and reset:**
  - `clr` for one cycle mid-run: all counters 0 and `locked` 0 after that edge; relock after 1+`LOCK_N` edges.
  - `rst` pulsed between edges: outputs 0 before the next posedge.
- **Wrap rollover:** `WRAP_W` = 2, 4 full counter periods.
  - `wraps` goes 1,2,3,0.
  - `wrap` pulses 4 times.
